// File: rtl/fp_result_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_check_pkg
// Description : Shared types and constants for the fp_unit result checker:
//               expected-entry record, canonical NaN encodings, checker
//               states and the entry builder.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_result_check_pkg;

    // Canonical quiet NaN produced by fp_unit for single and double formats
    localparam logic [31:0] FP_CNAN_S = 32'h7FC00000;
    localparam logic [63:0] FP_CNAN_D = 64'h7FF8000000000000;

    // Opcode bits whose NaN outputs are not canonicalised
    localparam int OP_FCMP_BIT     = 6;
    localparam int OP_FCVT_F2I_BIT = 9;

    // One queued expectation
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        nan_ok;
        logic        last;
    } fp_check_entry_type;

    // Checker state; DONE and FAIL are both terminal
    typedef enum logic [1:0] {
        CHK_RUN  = 2'd0,
        CHK_DONE = 2'd1,
        CHK_FAIL = 2'd2
    } fp_check_state_e;

    // Build an entry from the issue-side strobes
    function automatic fp_check_entry_type f_make_entry(
        input logic [63:0] result,
        input logic [4:0]  flags,
        input logic [1:0]  fmt,
        input logic [9:0]  opcode,
        input logic        last
    );
        fp_check_entry_type e;
        e.result = result;
        e.flags  = flags;
        e.fmt    = fmt;
        e.nan_ok = ~opcode[OP_FCVT_F2I_BIT] & ~opcode[OP_FCMP_BIT];
        e.last   = last;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_result_check_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp_check_fifo
// Description : Synchronous FIFO of expected-result entries. Wrap-around
//               read/write pointers plus an occupancy count, so all DEPTH
//               slots are usable and a push and a pop may share a cycle even
//               when full.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_check_fifo
    import fp_result_check_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  fp_check_entry_type i_data,
    output fp_check_entry_type o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = ADDR_W + 1;
    localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

    fp_check_entry_type r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_result_check.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_check
// Description : In-order result checker for fp_unit. Queues expectations at
//               issue, pops one per ready strobe, compares with the
//               canonical-NaN payload rule, counts passes and captures the
//               first failure. Compare results land one cycle after the pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_check
    import fp_result_check_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue_valid,
    input  logic [63:0]      i_issue_result,
    input  logic [4:0]       i_issue_flags,
    input  logic [1:0]       i_issue_fmt,
    input  logic [9:0]       i_issue_opcode,
    input  logic             i_issue_last,
    input  logic             i_calc_ready,
    input  logic [63:0]      i_calc_result,
    input  logic [4:0]       i_calc_flags,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_done,
    output logic             o_err,
    output logic             o_proto_err,
    output logic [CNT_W-1:0] o_err_index,
    output logic [63:0]      o_err_result_diff,
    output logic [4:0]       o_err_flags_diff
);

    // Masked result difference. A canonical NaN from the unit only has to
    // agree with the expected value in exponent and quiet bit, because the
    // reference model may carry any payload.
    function automatic logic [63:0] f_result_diff(
        input fp_check_entry_type exp_e,
        input logic [63:0]        calc
    );
        logic [63:0] diff;
        diff = calc ^ exp_e.result;
        if ((exp_e.fmt == 2'd0) && exp_e.nan_ok && (calc[31:0] == FP_CNAN_S)) begin
            diff = {32'h0, 1'b0, calc[30:22] ^ exp_e.result[30:22], 22'h0};
        end else if ((exp_e.fmt != 2'd0) && exp_e.nan_ok && (calc == FP_CNAN_D)) begin
            diff = {1'b0, calc[62:51] ^ exp_e.result[62:51], 51'h0};
        end
        return diff;
    endfunction

    fp_check_state_e    r_state;
    fp_check_state_e    w_state_nxt;
    fp_check_entry_type w_new_entry;
    fp_check_entry_type w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_run;
    logic               w_push_req;
    logic               w_pop_req;
    logic               w_push;
    logic               w_pop;
    logic               w_overflow;
    logic               w_underflow;
    logic               w_cmp_fail;
    logic               w_cmp_act;
    logic               w_stop;

    logic               r_cmp_valid;
    logic [63:0]        r_cmp_res_diff;
    logic [4:0]         r_cmp_flg_diff;
    logic               r_cmp_last;
    logic [CNT_W-1:0]   r_cmp_index;
    logic [CNT_W-1:0]   r_pop_idx;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic               r_proto_err;
    logic [CNT_W-1:0]   r_err_index;
    logic [63:0]        r_err_res_diff;
    logic [4:0]         r_err_flg_diff;

    assign w_new_entry = f_make_entry(i_issue_result, i_issue_flags, i_issue_fmt,
                                      i_issue_opcode, i_issue_last);

    // A pending compare that fails or ends the stream stops further pops, so
    // nothing is consumed past the terminal entry.
    assign w_cmp_fail  = (|r_cmp_res_diff) || (|r_cmp_flg_diff);
    assign w_run       = (r_state == CHK_RUN);
    assign w_cmp_act   = r_cmp_valid && w_run;
    assign w_stop      = r_cmp_valid && (w_cmp_fail || r_cmp_last);
    assign w_push_req  = i_issue_valid && w_run;
    assign w_pop_req   = i_calc_ready && w_run && !w_stop;
    assign w_pop       = w_pop_req && !w_fifo_empty;
    assign w_push      = w_push_req && (!w_fifo_full || w_pop);
    assign w_overflow  = w_push_req && w_fifo_full && !w_pop;
    assign w_underflow = w_pop_req && w_fifo_empty;

    fp_check_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_new_entry),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CHK_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: resolve the registered compare
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CHK_RUN: begin
                if (w_cmp_act) begin
                    if (w_cmp_fail) begin
                        w_state_nxt = CHK_FAIL;
                    end else if (r_cmp_last) begin
                        w_state_nxt = CHK_DONE;
                    end
                end
            end
            CHK_DONE: w_state_nxt = CHK_DONE;
            CHK_FAIL: w_state_nxt = CHK_FAIL;
            default:  w_state_nxt = CHK_RUN;
        endcase
    end

    // Compare stage: register the diffs of the popped entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid    <= 1'b0;
            r_cmp_res_diff <= '0;
            r_cmp_flg_diff <= '0;
            r_cmp_last     <= 1'b0;
            r_cmp_index    <= '0;
        end else begin
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_cmp_res_diff <= f_result_diff(w_head, i_calc_result);
                r_cmp_flg_diff <= i_calc_flags ^ w_head.flags;
                r_cmp_last     <= w_head.last;
                r_cmp_index    <= r_pop_idx;
            end
        end
    end

    // Pop index and pass counter, both saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_idx  <= '0;
            r_pass_cnt <= '0;
        end else begin
            if (w_pop && (r_pop_idx != '1)) begin
                r_pop_idx <= r_pop_idx + CNT_W'(1);
            end
            if (w_cmp_act && !w_cmp_fail && (r_pass_cnt != '1)) begin
                r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end
        end
    end

    // First-failure capture and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_index    <= '0;
            r_err_res_diff <= '0;
            r_err_flg_diff <= '0;
            r_proto_err    <= 1'b0;
        end else begin
            if (w_cmp_act && w_cmp_fail) begin
                r_err_index    <= r_cmp_index;
                r_err_res_diff <= r_cmp_res_diff;
                r_err_flg_diff <= r_cmp_flg_diff;
            end
            if (w_overflow || w_underflow) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_pass_cnt        = r_pass_cnt;
    assign o_fail_cnt        = CNT_W'(r_state == CHK_FAIL);
    assign o_done            = (r_state == CHK_DONE);
    assign o_err             = (r_state == CHK_FAIL);
    assign o_proto_err       = r_proto_err;
    assign o_err_index       = r_err_index;
    assign o_err_result_diff = r_err_res_diff;
    assign o_err_flags_diff  = r_err_flg_diff;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_result_check
// Description : Directed self-checking bench for fp_result_check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_result_check;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             i_issue_valid;
    logic [63:0]      i_issue_result;
    logic [4:0]       i_issue_flags;
    logic [1:0]       i_issue_fmt;
    logic [9:0]       i_issue_opcode;
    logic             i_issue_last;
    logic             i_calc_ready;
    logic [63:0]      i_calc_result;
    logic [4:0]       i_calc_flags;
    logic [CNT_W-1:0] o_pass_cnt;
    logic [CNT_W-1:0] o_fail_cnt;
    logic             o_done;
    logic             o_err;
    logic             o_proto_err;
    logic [CNT_W-1:0] o_err_index;
    logic [63:0]      o_err_result_diff;
    logic [4:0]       o_err_flags_diff;

    int n_vec;
    int n_miss;

    localparam logic [9:0] OP_FADD = 10'h001;
    localparam logic [9:0] OP_FCMP = 10'h040;

    fp_result_check #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_issue_valid     (i_issue_valid),
        .i_issue_result    (i_issue_result),
        .i_issue_flags     (i_issue_flags),
        .i_issue_fmt       (i_issue_fmt),
        .i_issue_opcode    (i_issue_opcode),
        .i_issue_last      (i_issue_last),
        .i_calc_ready      (i_calc_ready),
        .i_calc_result     (i_calc_result),
        .i_calc_flags      (i_calc_flags),
        .o_pass_cnt        (o_pass_cnt),
        .o_fail_cnt        (o_fail_cnt),
        .o_done            (o_done),
        .o_err             (o_err),
        .o_proto_err       (o_proto_err),
        .o_err_index       (o_err_index),
        .o_err_result_diff (o_err_result_diff),
        .o_err_flags_diff  (o_err_flags_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_issue_valid  = 1'b0;
        i_issue_result = '0;
        i_issue_flags  = '0;
        i_issue_fmt    = '0;
        i_issue_opcode = '0;
        i_issue_last   = 1'b0;
        i_calc_ready   = 1'b0;
        i_calc_result  = '0;
        i_calc_flags   = '0;
    endtask

    // One clock with the given issue/calc strobes; returns 1 time unit after the edge
    task automatic cyc(input logic iv, input logic [63:0] ires, input logic [4:0] ifl,
                       input logic [1:0] ifmt, input logic [9:0] iop, input logic ilast,
                       input logic cr, input logic [63:0] cres, input logic [4:0] cfl);
        i_issue_valid  = iv;
        i_issue_result = ires;
        i_issue_flags  = ifl;
        i_issue_fmt    = ifmt;
        i_issue_opcode = iop;
        i_issue_last   = ilast;
        i_calc_ready   = cr;
        i_calc_result  = cres;
        i_calc_flags   = cfl;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (o_pass_cnt !== 32'd0) begin n_miss++; $display("FAIL reset_pass_cnt got %0d want 0", o_pass_cnt); end
        n_vec++; if (o_fail_cnt !== 32'd0) begin n_miss++; $display("FAIL reset_fail_cnt got %0d want 0", o_fail_cnt); end
        n_vec++; if ({o_done, o_err, o_proto_err} !== 3'b000) begin n_miss++; $display("FAIL reset_flags got %b want 000", {o_done, o_err, o_proto_err}); end
        n_vec++; if (o_err_result_diff !== 64'h0) begin n_miss++; $display("FAIL reset_res_diff got %h want 0", o_err_result_diff); end
    endtask

    task automatic test_pass_stream();
        do_reset();
        cyc(1, 64'h3F800000, 5'h0, 2'd0, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(1, 64'h40000000, 5'h0, 2'd0, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(1, 64'h40400000, 5'h0, 2'd0, OP_FADD, 1, 0, 64'h0, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h3F800000, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h40000000, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h40400000, 5'h0);
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd3) begin n_miss++; $display("FAIL stream_pass_cnt got %0d want 3", o_pass_cnt); end
        n_vec++; if (o_done !== 1'b1) begin n_miss++; $display("FAIL stream_done got %b want 1", o_done); end
        n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL stream_err got %b want 0", o_err); end
        n_vec++; if (o_fail_cnt !== 32'd0) begin n_miss++; $display("FAIL stream_fail_cnt got %0d want 0", o_fail_cnt); end
    endtask

    task automatic test_nan_single();
        do_reset();
        cyc(1, 64'h7FC00001, 5'h0, 2'd0, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h7FC00000, 5'h0);
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd1) begin n_miss++; $display("FAIL nan_s_pass got %0d want 1", o_pass_cnt); end
        n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL nan_s_err_clean got %b want 0", o_err); end
        cyc(1, 64'h7FC00001, 5'h0, 2'd0, OP_FCMP, 0, 0, 64'h0, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h7FC00000, 5'h0);
        idle(2);
        n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL nan_s_fcmp_err got %b want 1", o_err); end
        n_vec++; if (o_err_result_diff !== 64'h1) begin n_miss++; $display("FAIL nan_s_fcmp_diff got %h want 1", o_err_result_diff); end
        n_vec++; if (o_err_index !== 32'd1) begin n_miss++; $display("FAIL nan_s_fcmp_index got %0d want 1", o_err_index); end
        n_vec++; if (o_fail_cnt !== 32'd1) begin n_miss++; $display("FAIL nan_s_fail_cnt got %0d want 1", o_fail_cnt); end
    endtask

    task automatic test_nan_double();
        do_reset();
        cyc(1, 64'h7FF4000000000000, 5'h0, 2'd1, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h7FF8000000000000, 5'h0);
        idle(2);
        // Only bits 62:51 are compared against a canonical NaN: bit 51 differs
        n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL nan_d_err got %b want 1", o_err); end
        n_vec++; if (o_err_result_diff !== 64'h0008000000000000) begin n_miss++; $display("FAIL nan_d_diff got %h want 0008000000000000", o_err_result_diff); end
        n_vec++; if (o_err_index !== 32'd0) begin n_miss++; $display("FAIL nan_d_index got %0d want 0", o_err_index); end
    endtask

    task automatic test_flags();
        do_reset();
        cyc(1, 64'h3F800000, 5'h00, 2'd0, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(1, 64'h40000000, 5'h01, 2'd0, OP_FADD, 0, 0, 64'h0, 5'h0);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h3F800000, 5'h00);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h40000000, 5'h00);
        idle(2);
        n_vec++; if (o_err_index !== 32'd1) begin n_miss++; $display("FAIL flags_index got %0d want 1", o_err_index); end
        n_vec++; if (o_err_flags_diff !== 5'h01) begin n_miss++; $display("FAIL flags_diff got %h want 01", o_err_flags_diff); end
        n_vec++; if (o_err_result_diff !== 64'h0) begin n_miss++; $display("FAIL flags_res_diff got %h want 0", o_err_result_diff); end
        n_vec++; if (o_pass_cnt !== 32'd1) begin n_miss++; $display("FAIL flags_pass got %0d want 1", o_pass_cnt); end
        cyc(1, 64'h40400000, 5'h00, 2'd0, OP_FADD, 0, 1, 64'h40400000, 5'h00);
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h40400000, 5'h00);
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd1) begin n_miss++; $display("FAIL flags_frozen_pass got %0d want 1", o_pass_cnt); end
        n_vec++; if (o_err_index !== 32'd1) begin n_miss++; $display("FAIL flags_frozen_index got %0d want 1", o_err_index); end
        n_vec++; if (o_proto_err !== 1'b0) begin n_miss++; $display("FAIL flags_frozen_proto got %b want 0", o_proto_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 64'(k), 5'h0, 2'd1, OP_FADD, (k == 5), 0, 64'h0, 5'h0);
        end
        n_vec++; if (o_proto_err !== 1'b1) begin n_miss++; $display("FAIL ovf_proto got %b want 1", o_proto_err); end
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'(k), 5'h0);
        end
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd4) begin n_miss++; $display("FAIL ovf_pass got %0d want 4", o_pass_cnt); end
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'd5, 5'h0);
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd4) begin n_miss++; $display("FAIL ovf_dropped_pass got %0d want 4", o_pass_cnt); end
        n_vec++; if (o_done !== 1'b0) begin n_miss++; $display("FAIL ovf_dropped_done got %b want 0", o_done); end
    endtask

    task automatic test_underflow();
        do_reset();
        n_vec++; if (o_proto_err !== 1'b0) begin n_miss++; $display("FAIL unf_pre got %b want 0", o_proto_err); end
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'h0, 5'h0);
        n_vec++; if (o_proto_err !== 1'b1) begin n_miss++; $display("FAIL unf_proto got %b want 1", o_proto_err); end
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd0) begin n_miss++; $display("FAIL unf_pass got %0d want 0", o_pass_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1, 64'(k), 5'h0, 2'd1, OP_FADD, 0, 0, 64'h0, 5'h0);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(1, 64'(k + 4), 5'h0, 2'd1, OP_FADD, 0, 1, 64'(k), 5'h0);
        end
        idle(2);
        n_vec++; if (o_pass_cnt !== 32'd20) begin n_miss++; $display("FAIL b2b_pass got %0d want 20", o_pass_cnt); end
        n_vec++; if (o_proto_err !== 1'b0) begin n_miss++; $display("FAIL b2b_proto got %b want 0", o_proto_err); end
        n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL b2b_err got %b want 0", o_err); end
    endtask

    task automatic test_reset_midrun();
        // Keep the pipeline busy, then drop reset between edges
        i_issue_valid  = 1'b1;
        i_issue_result = 64'd24;
        i_issue_fmt    = 2'd1;
        i_issue_opcode = OP_FADD;
        i_calc_ready   = 1'b1;
        i_calc_result  = 64'd20;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (o_pass_cnt !== 32'd0) begin n_miss++; $display("FAIL midrst_pass got %0d want 0", o_pass_cnt); end
        n_vec++; if ({o_done, o_err, o_proto_err} !== 3'b000) begin n_miss++; $display("FAIL midrst_flags got %b want 000", {o_done, o_err, o_proto_err}); end
        n_vec++; if (o_fail_cnt !== 32'd0 || o_err_index !== 32'd0) begin n_miss++; $display("FAIL midrst_capture got %0d/%0d want 0/0", o_fail_cnt, o_err_index); end
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        // Flushed FIFO: a ready now is an underflow
        cyc(0, 64'h0, 5'h0, 2'd0, 10'h0, 0, 1, 64'd20, 5'h0);
        n_vec++; if (o_proto_err !== 1'b1) begin n_miss++; $display("FAIL midrst_flushed got %b want 1", o_proto_err); end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b1;
        clear_inputs();
        test_reset();
        test_pass_stream();
        test_nan_single();
        test_nan_double();
        test_flags();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
